bmd_256_latency_ctrl: RTL

//  Sequences the latency-check timestamp BRAM (14b addr, 64b data, 2-cycle read port).
//  - On TX of a tagged packet: writes the free-running latency_counter to BRAM[tag].
//  - On RX of the same tag: reads the stamp back, computes round-trip delta, updates stats.
//  - Sits between TX_ENGINE/RX_ENGINE and the BRAM; owns all BRAM ports including rstb.

---
 rtl/bmd_lat_pkg.sv | 24 ++
 rtl/bmd_256_latency_ctrl_if.sv | 48 ++++
 rtl/bmd_lat_stats.sv | 64 ++++++
 rtl/bmd_256_latency_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/bmd_lat_pkg.sv
// Shared types, default widths and the saturating adder for the latency-check controller.
package bmd_lat_pkg;

  localparam int LAT_ADDR_W = 14;
  localparam int LAT_DATA_W = 64;
  localparam int LAT_RD_LAT = 2;
  localparam int LAT_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lat_state_e;

  // MSB of the result flags saturation; the lower bits are the clamped sum.
  function automatic logic [LAT_DATA_W:0] sat_add(input logic [LAT_DATA_W-1:0] a,
                                                  input logic [LAT_DATA_W-1:0] b);
    logic [LAT_DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[LAT_DATA_W]) s = '1;
    return s;
  endfunction

endpackage

// File: rtl/bmd_256_latency_ctrl_if.sv
// Engine/BRAM/status bundle of the latency-check controller.
interface bmd_256_latency_ctrl_if #(
  parameter int ADDR_W = bmd_lat_pkg::LAT_ADDR_W,
  parameter int DATA_W = bmd_lat_pkg::LAT_DATA_W,
  parameter int CNT_W  = bmd_lat_pkg::LAT_CNT_W
);
  logic [DATA_W-1:0] latency_counter;
  logic              start;
  logic              clr;
  logic [CNT_W-1:0]  sample_target;
  logic              tx_stamp;
  logic [ADDR_W-1:0] tx_tag;
  logic              rx_stamp;
  logic [ADDR_W-1:0] rx_tag;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic              bram_reb;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic              bram_rstb;
  logic [DATA_W-1:0] bram_rd_data;
  logic              busy;
  logic              done;
  logic              lat_valid;
  logic [DATA_W-1:0] lat_last;
  logic [DATA_W-1:0] lat_min;
  logic [DATA_W-1:0] lat_max;
  logic [DATA_W-1:0] lat_sum;
  logic              sum_ovf;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport slave (
    input  latency_counter, start, clr, sample_target, tx_stamp, tx_tag, rx_stamp, rx_tag,
           bram_rd_data,
    output bram_wea, bram_wr_addr, bram_wr_data, bram_reb, bram_rd_addr, bram_rstb,
           busy, done, lat_valid, lat_last, lat_min, lat_max, lat_sum, sum_ovf,
           sample_cnt, err_cnt
  );

  modport master (
    output latency_counter, start, clr, sample_target, tx_stamp, tx_tag, rx_stamp, rx_tag,
           bram_rd_data,
    input  bram_wea, bram_wr_addr, bram_wr_data, bram_reb, bram_rd_addr, bram_rstb,
           busy, done, lat_valid, lat_last, lat_min, lat_max, lat_sum, sum_ovf,
           sample_cnt, err_cnt
  );
endinterface

// File: rtl/bmd_lat_stats.sv
// Latency statistics accumulator: last/min/max, saturating sum and sample/error counters.
module bmd_lat_stats
  import bmd_lat_pkg::*;
#(
  parameter int DATA_W = LAT_DATA_W,
  parameter int CNT_W  = LAT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_delta,
  output logic              o_lat_valid,
  output logic [DATA_W-1:0] o_lat_last,
  output logic [DATA_W-1:0] o_lat_min,
  output logic [DATA_W-1:0] o_lat_max,
  output logic [DATA_W-1:0] o_lat_sum,
  output logic              o_sum_ovf,
  output logic [CNT_W-1:0]  o_sample_cnt,
  output logic [CNT_W-1:0]  o_err_cnt
);
  logic              r_lat_valid;
  logic [DATA_W-1:0] r_last, r_min, r_max, r_sum;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt, r_err;
  logic [DATA_W:0]   w_sum_next;

  assign w_sum_next = sat_add(r_sum, i_delta);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_lat_valid <= 1'b0;
      r_last      <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_err       <= '0;
    end else begin
      r_lat_valid <= i_valid && !i_err;
      if (i_valid && i_err) begin
        if (!(&r_err)) r_err <= r_err + CNT_W'(1);
      end else if (i_valid) begin
        r_last <= i_delta;
        if (i_delta < r_min) r_min <= i_delta;
        if (i_delta > r_max) r_max <= i_delta;
        r_sum <= w_sum_next[DATA_W-1:0];
        if (w_sum_next[DATA_W]) r_ovf <= 1'b1;
        if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_lat_valid  = r_lat_valid;
  assign o_lat_last   = r_last;
  assign o_lat_min    = r_min;
  assign o_lat_max    = r_max;
  assign o_lat_sum    = r_sum;
  assign o_sum_ovf    = r_ovf;
  assign o_sample_cnt = r_cnt;
  assign o_err_cnt    = r_err;
endmodule

// File: rtl/bmd_256_latency_ctrl.sv
// Latency-check controller: stamps tagged TX packets into BRAM and measures round trip on RX.
// state | meaning: IDLE idle, stamps ignored | RUN stamping and measuring | DONE target reached, TX still stamped
module bmd_256_latency_ctrl
  import bmd_lat_pkg::*;
#(
  parameter int ADDR_W = LAT_ADDR_W,
  parameter int DATA_W = LAT_DATA_W,
  parameter int RD_LAT = LAT_RD_LAT,
  parameter int CNT_W  = LAT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  bmd_256_latency_ctrl_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] now;
    logic              byp;
    logic [DATA_W-1:0] byp_data;
  } rd_stage_t;

  lat_state_e        r_state;
  logic              r_busy, r_done;
  rd_stage_t         r_pipe [RD_LAT];
  rd_stage_t         w_head;
  logic              w_wea, w_reb, w_collide, w_err, w_accept, w_stat_clr, w_hit_target;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0] w_stamp, w_delta;

  assign w_wea     = bus.tx_stamp && (r_state != ST_IDLE) && !bus.clr && !rst;
  assign w_reb     = bus.rx_stamp && (r_state == ST_RUN) && !bus.clr && !rst;
  assign w_wr_addr = w_wea ? bus.tx_tag : '0;
  assign w_rd_addr = w_reb ? bus.rx_tag : '0;
  // Same-cycle write and read of one tag: BRAM output is undefined, so reuse the write data.
  assign w_collide = w_wea && w_reb && (bus.tx_tag == bus.rx_tag);

  assign bus.bram_wea     = w_wea;
  assign bus.bram_wr_addr = w_wr_addr;
  assign bus.bram_wr_data = w_wea ? bus.latency_counter : '0;
  assign bus.bram_reb     = w_reb;
  assign bus.bram_rd_addr = w_rd_addr;
  assign bus.bram_rstb    = bus.clr;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_reb, now: bus.latency_counter, byp: w_collide,
                     byp_data: bus.latency_counter};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_head       = r_pipe[RD_LAT-1];
  assign w_stamp      = w_head.byp ? w_head.byp_data : bus.bram_rd_data;
  assign w_err        = w_stamp > w_head.now;
  assign w_delta      = w_head.now - w_stamp;
  assign w_accept     = w_head.valid && !w_err;
  assign w_stat_clr   = bus.clr || ((r_state == ST_DONE) && bus.start);
  assign w_hit_target = (bus.sample_target != '0) &&
                        ((bus.sample_cnt + CNT_W'(1)) == bus.sample_target);

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (bus.start) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
        ST_RUN: if (w_accept && w_hit_target) begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  bmd_lat_stats #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_stat_clr),
    .i_valid      (w_head.valid),
    .i_err        (w_err),
    .i_delta      (w_delta),
    .o_lat_valid  (bus.lat_valid),
    .o_lat_last   (bus.lat_last),
    .o_lat_min    (bus.lat_min),
    .o_lat_max    (bus.lat_max),
    .o_lat_sum    (bus.lat_sum),
    .o_sum_ovf    (bus.sum_ovf),
    .o_sample_cnt (bus.sample_cnt),
    .o_err_cnt    (bus.err_cnt)
  );
endmodule
